// File: rtl/x_ff_bank_ctrl_pkg.sv
// Shared types for the flip-flop bank controller: state encoding, requester indices, word decode.
package x_ff_bank_pkg;

   typedef enum logic [1:0] {INIT, ARB, WR, CMD} state_t;

   localparam int unsigned REQ0      = 0;
   localparam int unsigned REQ1      = 1;
   localparam int unsigned MAX_DEPTH = 256;

   // Out-of-range index decodes to all-zero, so no word is enabled.
   function automatic logic [MAX_DEPTH-1:0] onehot(input int unsigned idx, input int unsigned depth);
      onehot = '0;
      if (idx < depth && idx < MAX_DEPTH) onehot = MAX_DEPTH'(1) << idx;
   endfunction

endpackage

// File: rtl/x_ff_bank_ctrl_if.sv
// Controller-side bundle: write requests, global commands, bank drive and status.
interface x_ff_bank_ctrl_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
);
   logic [1:0]       REQ_V;
   logic [AW-1:0]    REQ_ADDR0;
   logic [AW-1:0]    REQ_ADDR1;
   logic [WIDTH-1:0] REQ_DATA0;
   logic [WIDTH-1:0] REQ_DATA1;
   logic             CMD_CLR;
   logic             CMD_PRE;
   logic [1:0]       GNT;
   logic             CMD_ACK;
   logic [DEPTH-1:0] FF_CE;
   logic [WIDTH-1:0] FF_I;
   logic             FF_RST;
   logic             FF_SET;
   logic             BUSY;
   logic             INIT_DONE;
   logic             ERR;

   modport master (
      output REQ_V, REQ_ADDR0, REQ_ADDR1, REQ_DATA0, REQ_DATA1, CMD_CLR, CMD_PRE,
      input  GNT, CMD_ACK, FF_CE, FF_I, FF_RST, FF_SET, BUSY, INIT_DONE, ERR
   );

   modport slave (
      input  REQ_V, REQ_ADDR0, REQ_ADDR1, REQ_DATA0, REQ_DATA1, CMD_CLR, CMD_PRE,
      output GNT, CMD_ACK, FF_CE, FF_I, FF_RST, FF_SET, BUSY, INIT_DONE, ERR
   );
endinterface

// File: rtl/x_ff_bank_ctrl_rr_arb2.sv
// Two-way round-robin pick (combinational) with a registered preference pointer.
// Pointer moves past the winner only when adv is asserted.
module x_ff_rr_arb2
   import x_ff_bank_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       adv,
   output logic       win,
   output logic       any
);
   logic ptr;

   always_comb begin
      any = req[REQ0] | req[REQ1];
      if (req[REQ0] && req[REQ1]) win = ptr;
      else if (req[REQ1])         win = 1'(REQ1);
      else                        win = 1'(REQ0);
   end

   always_ff @(posedge clk) begin
      if (!rst)     ptr <= 1'(REQ0);
      else if (adv) ptr <= ~win;
   end
endmodule

// File: rtl/x_ff_bank_ctrl.sv
// Bank controller: DEPTH-cycle init walk, then 2-way round-robin writes and clear/preset commands (1 op per 2 cycles).
// Requests/commands are level-held until GNT/CMD_ACK; X_FF_BANK_CTRL_ADDR_CHK_EN flags out-of-range writes on ERR.
module x_ff_bank_ctrl
   import x_ff_bank_pkg::*;
#(
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      DEPTH    = 16,
   parameter int unsigned      AW       = 4,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input logic             CLK,
   input logic             RST,
   x_ff_bank_ctrl_if.slave bus
);
   state_t           st;
   logic [AW:0]      cnt;
   logic             win;
   logic             any;
   logic             cmd;
   logic             adv;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_data;

   always_comb begin
      cmd    = bus.CMD_CLR | bus.CMD_PRE;
      adv    = (st == ARB) && !cmd && any;
      w_addr = win ? bus.REQ_ADDR1 : bus.REQ_ADDR0;
      w_data = win ? bus.REQ_DATA1 : bus.REQ_DATA0;
   end

   x_ff_rr_arb2 u_arb (
      .clk (CLK),
      .rst (RST),
      .req (bus.REQ_V),
      .adv (adv),
      .win (win),
      .any (any)
   );

   // Outputs describe the state being executed in the current cycle; pulses default low.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         st            <= INIT;
         cnt           <= '0;
         bus.GNT       <= '0;
         bus.CMD_ACK   <= 1'b0;
         bus.FF_CE     <= '0;
         bus.FF_I      <= '0;
         bus.FF_RST    <= 1'b0;
         bus.FF_SET    <= 1'b0;
         bus.BUSY      <= 1'b1;
         bus.INIT_DONE <= 1'b0;
         bus.ERR       <= 1'b0;
      end else begin
         bus.GNT     <= '0;
         bus.CMD_ACK <= 1'b0;
         bus.FF_CE   <= '0;
         bus.FF_I    <= '0;
         bus.FF_RST  <= 1'b0;
         bus.FF_SET  <= 1'b0;
         bus.BUSY    <= 1'b0;
         bus.ERR     <= 1'b0;
         case (st)
            INIT: begin
               if (cnt < (AW+1)'(DEPTH)) begin
                  bus.FF_CE <= DEPTH'(onehot(32'(cnt), DEPTH));
                  bus.FF_I  <= INIT_VAL;
                  bus.BUSY  <= 1'b1;
                  cnt       <= cnt + (AW+1)'(1);
               end else begin
                  st            <= ARB;
                  bus.INIT_DONE <= 1'b1;
               end
            end
            ARB: begin
               if (cmd) begin
                  st          <= CMD;
                  bus.FF_RST  <= bus.CMD_CLR;
                  bus.FF_SET  <= bus.CMD_PRE & ~bus.CMD_CLR;
                  bus.CMD_ACK <= 1'b1;
                  bus.BUSY    <= 1'b1;
               end else if (any) begin
                  st        <= WR;
                  bus.FF_CE <= DEPTH'(onehot(32'(w_addr), DEPTH));
                  bus.FF_I  <= w_data;
                  bus.GNT   <= win ? 2'b10 : 2'b01;
                  bus.BUSY  <= 1'b1;
`ifdef X_FF_BANK_CTRL_ADDR_CHK_EN
                  bus.ERR   <= (32'(w_addr) >= DEPTH);
`endif
               end
            end
            default: st <= ARB;
         endcase
      end
   end
endmodule

// File: tb/tb_x_ff_bank_ctrl.sv
// Bench for x_ff_bank_ctrl: DEPTH=16 and DEPTH=12 instances share stimulus; directed table plus random traffic vs a cycle model.
module tb_x_ff_bank_ctrl;

`ifdef X_FF_BANK_CTRL_ADDR_CHK_EN
   localparam bit ADDR_CHK = 1'b1;
`else
   localparam bit ADDR_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] req_v;
   logic [3:0] a0, a1;
   logic [7:0] d0, d1;
   logic       clr, pre;

   int tests = 0;
   int fails = 0;

   x_ff_bank_ctrl_if #(.WIDTH(8), .DEPTH(16), .AW(4)) bus16 ();
   x_ff_bank_ctrl_if #(.WIDTH(8), .DEPTH(12), .AW(4)) bus12 ();

   assign bus16.REQ_V = req_v;  assign bus12.REQ_V = req_v;
   assign bus16.REQ_ADDR0 = a0; assign bus12.REQ_ADDR0 = a0;
   assign bus16.REQ_ADDR1 = a1; assign bus12.REQ_ADDR1 = a1;
   assign bus16.REQ_DATA0 = d0; assign bus12.REQ_DATA0 = d0;
   assign bus16.REQ_DATA1 = d1; assign bus12.REQ_DATA1 = d1;
   assign bus16.CMD_CLR = clr;  assign bus12.CMD_CLR = clr;
   assign bus16.CMD_PRE = pre;  assign bus12.CMD_PRE = pre;

   x_ff_bank_ctrl #(.WIDTH(8), .DEPTH(16), .AW(4), .INIT_VAL(8'hA5)) dut16 (.CLK(clk), .RST(rst), .bus(bus16));
   x_ff_bank_ctrl #(.WIDTH(8), .DEPTH(12), .AW(4), .INIT_VAL(8'h3C)) dut12 (.CLK(clk), .RST(rst), .bus(bus12));

   // Reference model: cycles since reset release, whether last cycle was an operation, RR preference.
   int         m_c[2];
   bit         m_prev[2];
   int         m_ptr[2];
   logic [1:0] e_gnt[2];
   logic       e_ack[2], e_rst[2], e_set[2], e_busy[2], e_done[2], e_err[2];
   logic [15:0] e_ce[2];
   logic [7:0] e_i[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int i);
      int         dep;
      int         w;
      logic [3:0] ad;
      logic [7:0] iv;
      dep = (i == 0) ? 16 : 12;
      iv  = (i == 0) ? 8'hA5 : 8'h3C;
      e_gnt[i] = 2'b00; e_ack[i] = 1'b0; e_ce[i] = 16'h0; e_i[i] = 8'h0;
      e_rst[i] = 1'b0;  e_set[i] = 1'b0; e_err[i] = 1'b0;
      if (!rst) begin
         m_c[i] = 0; m_prev[i] = 1'b0; m_ptr[i] = 0;
         e_busy[i] = 1'b1; e_done[i] = 1'b0;
      end else begin
         if (m_c[i] < 1000) m_c[i]++;
         if (m_c[i] <= dep) begin
            e_ce[i]   = 16'(1) << (m_c[i] - 1);
            e_i[i]    = iv;
            e_busy[i] = 1'b1;
            e_done[i] = 1'b0;
         end else begin
            e_done[i] = 1'b1;
            e_busy[i] = 1'b0;
            if (m_c[i] == dep + 1 || m_prev[i]) begin
               m_prev[i] = 1'b0;
            end else if (clr || pre) begin
               e_rst[i] = clr; e_set[i] = pre && !clr; e_ack[i] = 1'b1;
               e_busy[i] = 1'b1; m_prev[i] = 1'b1;
            end else if (req_v != 2'b00) begin
               w = (req_v == 2'b11) ? m_ptr[i] : (req_v[1] ? 1 : 0);
               ad = (w == 1) ? a1 : a0;
               e_gnt[i] = 2'(1 << w);
               if (int'(ad) < dep) e_ce[i] = 16'(1) << ad;
               e_i[i]   = (w == 1) ? d1 : d0;
               e_err[i] = ADDR_CHK && (int'(ad) >= dep);
               e_busy[i] = 1'b1; m_prev[i] = 1'b1; m_ptr[i] = 1 - w;
            end
         end
      end
   endtask

   task automatic chk_dut(input int i, input logic [1:0] g, input logic a, input logic [15:0] ce,
                          input logic [7:0] fi, input logic r, input logic s, input logic b,
                          input logic d, input logic er);
      chk($sformatf("m%0d_gnt", i),  g,  e_gnt[i]);
      chk($sformatf("m%0d_ack", i),  a,  e_ack[i]);
      chk($sformatf("m%0d_ce", i),   ce, e_ce[i]);
      chk($sformatf("m%0d_ffi", i),  fi, e_i[i]);
      chk($sformatf("m%0d_rst", i),  r,  e_rst[i]);
      chk($sformatf("m%0d_set", i),  s,  e_set[i]);
      chk($sformatf("m%0d_busy", i), b,  e_busy[i]);
      chk($sformatf("m%0d_done", i), d,  e_done[i]);
      chk($sformatf("m%0d_err", i),  er, e_err[i]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      chk_dut(0, bus16.GNT, bus16.CMD_ACK, bus16.FF_CE, bus16.FF_I, bus16.FF_RST, bus16.FF_SET,
              bus16.BUSY, bus16.INIT_DONE, bus16.ERR);
      chk_dut(1, bus12.GNT, bus12.CMD_ACK, {4'h0, bus12.FF_CE}, bus12.FF_I, bus12.FF_RST, bus12.FF_SET,
              bus12.BUSY, bus12.INIT_DONE, bus12.ERR);
   endtask

   task automatic walk_check();
      for (int k = 0; k < 16; k++) begin
         cycle();
         chk("walk_ce",   bus16.FF_CE, 32'(1) << k);
         chk("walk_ffi",  bus16.FF_I, 8'hA5);
         chk("walk_gnt",  bus16.GNT, 2'b00);
         chk("walk_done", bus16.INIT_DONE, 1'b0);
      end
      cycle();
      chk("done_rise", bus16.INIT_DONE, 1'b1);
      chk("busy_low",  bus16.BUSY, 1'b0);
      chk("idle_ce",   bus16.FF_CE, 16'h0);
   endtask

   typedef struct {
      logic [1:0]  req;
      logic [7:0]  d0, d1;
      logic        clr, pre;
      logic [1:0]  gnt;
      logic        ack;
      logic [15:0] ce;
      logic [7:0]  ffi;
      logic        frst, fset;
   } vec_t;

   vec_t tbl[15];

   initial begin
      // Inputs apply before the edge; expectations hold for the cycle after it. addr0=3, addr1=9.
      tbl[0]  = '{2'b11, 8'h10, 8'h11, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0008, 8'h10, 1'b0, 1'b0};
      tbl[1]  = '{2'b11, 8'h12, 8'h11, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      tbl[2]  = '{2'b11, 8'h12, 8'h11, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0200, 8'h11, 1'b0, 1'b0};
      tbl[3]  = '{2'b11, 8'h12, 8'h13, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      tbl[4]  = '{2'b11, 8'h12, 8'h13, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0008, 8'h12, 1'b0, 1'b0};
      tbl[5]  = '{2'b11, 8'h14, 8'h13, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      tbl[6]  = '{2'b11, 8'h14, 8'h13, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0200, 8'h13, 1'b0, 1'b0};
      tbl[7]  = '{2'b01, 8'h14, 8'h13, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      tbl[8]  = '{2'b01, 8'h14, 8'h13, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0};
      tbl[9]  = '{2'b01, 8'h14, 8'h13, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      tbl[10] = '{2'b01, 8'h14, 8'h13, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0008, 8'h14, 1'b0, 1'b0};
      tbl[11] = '{2'b00, 8'h14, 8'h13, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      tbl[12] = '{2'b00, 8'h14, 8'h13, 1'b0, 1'b1, 2'b00, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1};
      tbl[13] = '{2'b00, 8'h14, 8'h13, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      tbl[14] = '{2'b00, 8'h14, 8'h13, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};

      rst = 1'b0; req_v = 2'b11; a0 = 4'd3; a1 = 4'd9; d0 = 8'h10; d1 = 8'h11; clr = 1'b0; pre = 1'b0;
      repeat (3) cycle();
      chk("rst_gnt",  bus16.GNT, 2'b00);
      chk("rst_ce",   bus16.FF_CE, 16'h0);
      chk("rst_busy", bus16.BUSY, 1'b1);
      chk("rst_done", bus16.INIT_DONE, 1'b0);
      chk("rst_ffi",  bus16.FF_I, 8'h00);

      rst = 1'b1;
      walk_check();

      for (int v = 0; v < 15; v++) begin
         req_v = tbl[v].req; d0 = tbl[v].d0; d1 = tbl[v].d1; clr = tbl[v].clr; pre = tbl[v].pre;
         cycle();
         chk($sformatf("tbl%0d_gnt", v), bus16.GNT, tbl[v].gnt);
         chk($sformatf("tbl%0d_ack", v), bus16.CMD_ACK, tbl[v].ack);
         chk($sformatf("tbl%0d_ce", v),  bus16.FF_CE, tbl[v].ce);
         chk($sformatf("tbl%0d_ffi", v), bus16.FF_I, tbl[v].ffi);
         chk($sformatf("tbl%0d_rst", v), bus16.FF_RST, tbl[v].frst);
         chk($sformatf("tbl%0d_set", v), bus16.FF_SET, tbl[v].fset);
      end

      // Out-of-range write on the 12-word bank after a common re-init.
      rst = 1'b0; req_v = 2'b00; clr = 1'b0; pre = 1'b0;
      cycle();
      rst = 1'b1;
      repeat (17) cycle();
      req_v = 2'b01; a0 = 4'd15; d0 = 8'h77;
      cycle();
      chk("oob12_gnt", bus12.GNT, 2'b01);
      chk("oob12_ce",  bus12.FF_CE, 12'h000);
      chk("oob12_err", bus12.ERR, ADDR_CHK);
      chk("oob16_ce",  bus16.FF_CE, 16'h8000);
      chk("oob16_err", bus16.ERR, 1'b0);
      req_v = 2'b00;
      cycle();
      chk("oob12_err_end", bus12.ERR, 1'b0);

      // Reset asserted while a write is on the bank.
      req_v = 2'b01; a0 = 4'd3; d0 = 8'h55;
      cycle();
      chk("wr_gnt", bus16.GNT, 2'b01);
      chk("wr_ce",  bus16.FF_CE, 16'h0008);
      rst = 1'b0; req_v = 2'b00;
      cycle();
      chk("midrst_gnt",  bus16.GNT, 2'b00);
      chk("midrst_ce",   bus16.FF_CE, 16'h0);
      chk("midrst_done", bus16.INIT_DONE, 1'b0);
      chk("midrst_busy", bus16.BUSY, 1'b1);
      rst = 1'b1;
      walk_check();

      // Random traffic: requesters and commands hold until the model says they were served.
      for (int n = 0; n < 2000; n++) begin
         for (int r = 0; r < 2; r++) begin
            if ((req_v[r] && e_gnt[0][r]) || (!req_v[r] && $urandom_range(3, 0) == 0)) begin
               req_v[r] = 1'($urandom_range(1, 0)) | !req_v[r];
               if (r == 0) begin a0 = 4'($urandom_range(15, 0)); d0 = 8'($urandom); end
               else        begin a1 = 4'($urandom_range(15, 0)); d1 = 8'($urandom); end
            end
         end
         if ((clr || pre) && e_ack[0]) begin clr = 1'b0; pre = 1'b0; end
         if (!(clr || pre) && $urandom_range(7, 0) == 0) {clr, pre} = 2'($urandom_range(3, 1));
         if (!rst) rst = 1'b1;
         else if ($urandom_range(299, 0) == 0) rst = 1'b0;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/x_ff_bank_ctrl.md
Name: x_ff_bank_ctrl

Overview:
Sequencing and arbitration controller for a bank of DEPTH flip-flop words, each word WIDTH X_FF-style cells sharing CE/SET/RST/I controls. After reset it walks the bank and loads INIT_VAL into every word. It then shares write access between two requesters using round-robin arbitration, and services global clear/preset commands through the cells' RST/SET pins. It sits between the simulation-primitive bank and the logic that configures it.

Parameters:
WIDTH, 8, bits per word (FF_I width)
DEPTH, 16, number of words; one FF_CE bit per word
AW, 4, address width; DEPTH <= 2**AW
INIT_VAL, 0, WIDTH-bit value written to every word during the init walk

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-low; sampled on CLK rising edge
REQ_V  in  2  request valid; bit n for requester n; held until GNT[n]
REQ_ADDR0  in  AW  requester 0 target word
REQ_ADDR1  in  AW  requester 1 target word
REQ_DATA0  in  WIDTH  requester 0 write data
REQ_DATA1  in  WIDTH  requester 1 write data
CMD_CLR  in  1  global clear request; level, held until CMD_ACK
CMD_PRE  in  1  global preset request; level, held until CMD_ACK
GNT  out  2  one-cycle grant pulse, at most one bit set
CMD_ACK  out  1  one-cycle command acknowledge
FF_CE  out  DEPTH  one-hot (or zero) word clock enable
FF_I  out  WIDTH  shared data to bank
FF_RST  out  1  bank reset pulse
FF_SET  out  1  bank set pulse
BUSY  out  1  high in INIT, WR, CMD
INIT_DONE  out  1  high once the init walk completes; sticky until RST low
ERR  out  1  address-check error pulse (feature only; tied 0 otherwise)

Behaviour:
- All outputs registered. While RST=0: state INIT, walk counter=0, rr pointer=0, GNT=0, CMD_ACK=0, FF_CE=0, FF_I=0, FF_RST=0, FF_SET=0, BUSY=1, INIT_DONE=0, ERR=0.
- States: INIT, ARB, WR, CMD.
- INIT: for k=0..DEPTH-1, one word per cycle: FF_CE=1<<k, FF_I=INIT_VAL. After k=DEPTH-1: go to ARB, INIT_DONE=1, BUSY=0. Requests and commands are ignored (no GNT/ACK) during INIT. Walk takes exactly DEPTH cycles after RST deasserts.
- ARB, priority: command > write. If CMD_CLR or CMD_PRE is high, go to CMD. Else if any REQ_V is high, the rr arbiter picks the winner, latches its addr/data, and goes to WR. Else stay in ARB.
- CMD (1 cycle): FF_RST=CMD_CLR, or FF_SET=CMD_PRE only if CMD_CLR=0 (clear dominates preset). CMD_ACK=1, FF_CE=0. Return to ARB. If both are high, one ACK clears both requests.
- WR (1 cycle): FF_CE=onehot(addr), FF_I=latched data, GNT[winner]=1. Return to ARB.
- Requester deasserts REQ_V (or presents a new request) on the edge ending its GNT cycle. Peak throughput is 1 write per 2 cycles.
- Round-robin: pointer names the preferred requester. After a grant, the pointer moves to the other requester. A lone requester always wins.
- Address >= DEPTH without the feature: FF_CE=0 in WR, GNT still pulses (silent drop).
- RST low mid-operation (any state): immediate return to reset values on that edge, and the init walk restarts.

Optional Feature:
X_FF_BANK_CTRL_ADDR_CHK_EN
- Defined: in ARB, an out-of-range winner address still moves to WR. WR drives FF_CE=0, GNT[winner]=1 and ERR=1 for that single cycle.
- Undefined: ERR tied 0, silent drop as above.

Decomposition:
- Package x_ff_bank_pkg: state enum (INIT, ARB, WR, CMD), requester-index constants REQ0=0 and REQ1=1, onehot-decode function.
- Sub-module x_ff_rr_arb2: 2-way round-robin arbiter, combinational pick plus registered pointer with an advance-on-grant input.

Test Plan:
- Reset then release, DEPTH=16, INIT_VAL=8'hA5 -> FF_CE walks 0x0001..0x8000 over 16 cycles with FF_I=A5; INIT_DONE rises on cycle 17; no GNT during walk even with REQ_V=2'b11.
- REQ_V=2'b11 held continuously, fresh data each grant -> GNT alternates 01,10,01,10, each separated by one ARB cycle; FF_CE matches REQ_ADDR0=3 (0x0008) and REQ_ADDR1=9 (0x0200).
- CMD_CLR=1 and CMD_PRE=1 with REQ_V=2'b01 pending -> CMD cycle first with FF_RST=1, FF_SET=0, CMD_ACK=1; then WR grants requester 0.
- CMD_PRE alone -> single FF_SET pulse, CMD_ACK; FF_CE=0 throughout.
- REQ_ADDR0=15 vs DEPTH=12 -> GNT[0]=1, FF_CE=0; ERR=1 only when X_FF_BANK_CTRL_ADDR_CHK_EN is defined.
- RST driven low during WR cycle -> next edge: GNT=0, FF_CE=0, INIT_DONE=0; after release the full 16-cycle walk repeats.
